snake_body_trail: RTL and testbench
===================================

Name: snake_body_trail

Overview:
- Consumes the snake-head position and the food-eaten level, and keeps a ring-buffer history of sampled head positions.
- Renders body segments for the VGA mixer, which places them below the snake head and above food.
- Runs a per-frame sequential self-collision scan of head versus body and flags a hit for the system controller's halt logic.

Parameters:
MAX_SEGS, 16, ring-buffer depth and maximum body length (power of 2)
INIT_LEN, 2, body length after reset or clear
SEG_SIZE, 16, square segment sprite edge in pixels
HEAD_W, 64, head bounding-box width for the collision scan
HEAD_H, 48, head bounding-box height for the collision scan
SAMPLE_FRAMES, 4, frame ticks between position samples
SKIP_SEGS, 3, newest segments excluded from the self-collision scan

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst  in  1  asynchronous active-high reset
i_clear  in  1  synchronous restart pulse; acts like reset
i_active  in  1  system active; sampling and growth occur only when high
i_frame_tick  in  1  one-cycle pulse at the start of vertical blank
i_head_x  in  10  head top-left x
i_head_y  in  10  head top-left y
i_food_ate  in  1  food overlap level; rising edge means grow
i_pixel_x  in  10  current pixel x
i_pixel_y  in  10  current pixel y
i_video_on  in  1  active video
o_vga_r  out  4  body pixel red (0 = transparent)
o_vga_g  out  4  body pixel green
o_vga_b  out  4  body pixel blue
o_length  out  5  current body length, 0..MAX_SEGS
o_self_hit  out  1  sticky self-collision flag
o_scan_busy  out  1  high while a scan is in progress

Behaviour:
- Reset (i_rst high):
  - All buffer entries = (0,0); wr_ptr = 0; length = INIT_LEN.
  - Sample counter = 0; edge register = 0; FSM = IDLE.
  - All outputs 0 except o_length = INIT_LEN.
- i_clear (synchronous, highest priority after reset):
  - Every entry is loaded with the current (i_head_x, i_head_y).
  - length = INIT_LEN; o_self_hit cleared; FSM forced to IDLE; sample counter = 0.
- Sampling:
  - On i_frame_tick with i_active high, the sample counter increments.
  - When the counter reaches SAMPLE_FRAMES-1, the head position is written at wr_ptr, wr_ptr increments mod MAX_SEGS, and the counter returns to 0.
  - Logical segment k (k = 0 is newest) is the entry at wr_ptr-1-k.
- Growth:
  - The rising edge of i_food_ate (registered previous value) with i_active high increments length, saturating at MAX_SEGS.
  - Growth and a sample in the same cycle both take effect.
- Scan FSM:
  - IDLE -> SCAN on i_frame_tick with i_active; a scan index k starts at SKIP_SEGS.
  - SCAN: one segment per cycle. Overlap test uses 11-bit arithmetic: head_x < seg_x+SEG_SIZE && head_x+HEAD_W > seg_x && head_y < seg_y+SEG_SIZE && head_y+HEAD_H > seg_y.
  - The test applies only to segments with k < length. An overlap sets o_self_hit (sticky until reset or clear).
  - When k = MAX_SEGS-1 or k+1 >= length: SCAN -> DONE.
  - DONE -> IDLE after one cycle.
  - o_scan_busy is high in SCAN and DONE.
  - A frame tick during SCAN or DONE does not restart the scan but still advances the sample counter.
  - If length <= SKIP_SEGS, the FSM goes IDLE -> DONE -> IDLE with no hit.
  - The scan reads the head position registered at scan start.
- Render:
  - Combinational hit = OR over k < length of pixel inside [seg_x, seg_x+SEG_SIZE) x [seg_y, seg_y+SEG_SIZE), computed in 11 bits.
  - Colour output is registered, with 1-cycle latency from pixel inputs.
  - Colour is (0,A,2) on hit with i_video_on high, else (0,0,0).
  - Segment k = 0 (the newest) is also drawn; the head overdraws it in the mixer.
- Wrap-around: pointer arithmetic wraps modulo MAX_SEGS. Coordinates do not wrap, because of the 11-bit compare.

Decomposition:
- Shared package (snake_pkg): SEG_SIZE, HEAD_W, HEAD_H, BODY_COLOR constants, and coord_t (10-bit) / pos_t {x,y} typedefs.
- One natural sub-module: box_overlap (combinational 11-bit AABB compare), reused by the render path and the scan path.

Test Plan:
- Reset, then i_rst low; drive head (100,200), 4 active frame ticks -> entry written at ptr 0, o_length=2, pixel (105,205) gives colour (0,A,2) one cycle later.
- Pulse i_food_ate high 3 cycles twice (separated by low) -> o_length=4; hold high 20 cycles -> only one increment.
- 20 growth edges -> o_length saturates at 16; 17 samples -> wr_ptr wraps to 1 and the oldest position is no longer drawn.
- Length=6, segment k=4 at (300,300), head at (290,290), frame tick -> o_scan_busy high for 4 cycles (k=3..5 plus DONE), then o_self_hit=1 and it stays set.
- Same setup with the overlap only at k=1 (inside SKIP_SEGS) -> o_self_hit stays 0.
- i_clear mid-scan with head (50,60) -> next cycle FSM IDLE, o_self_hit=0, o_length=2, all drawn segments at (50,60); i_rst asserted asynchronously mid-frame -> outputs 0 immediately.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and position types for the snake body trail.
// Coordinates are 10-bit screen pixels; compares widen to 11 bits.
package snake_pkg;

  localparam int SEG_SIZE = 16;
  localparam int HEAD_W   = 64;
  localparam int HEAD_H   = 48;

  localparam logic [11:0] BODY_COLOR = 12'h0A2;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test in 11-bit arithmetic.
// Box A is (AW x AH) at (ax,ay); box B is (BW x BH) at (bx,by).
module box_overlap
  import snake_pkg::*;
#(
  parameter int AW = 1,
  parameter int AH = 1,
  parameter int BW = SEG_SIZE,
  parameter int BH = SEG_SIZE
) (
  input  coord_t i_ax,
  input  coord_t i_ay,
  input  coord_t i_bx,
  input  coord_t i_by,
  output logic   o_hit
);

  logic [10:0] ax_w;
  logic [10:0] ay_w;
  logic [10:0] bx_w;
  logic [10:0] by_w;

  assign ax_w = {1'b0, i_ax};
  assign ay_w = {1'b0, i_ay};
  assign bx_w = {1'b0, i_bx};
  assign by_w = {1'b0, i_by};

  assign o_hit = (ax_w < bx_w + 11'(BW))
              && (ax_w + 11'(AW) > bx_w)
              && (ay_w < by_w + 11'(BH))
              && (ay_w + 11'(AH) > by_w);

endmodule

// File: rtl/snake_body_trail.sv
// Snake body history ring buffer, body renderer and
// per-frame sequential head-versus-body collision scan.
module snake_body_trail
  import snake_pkg::*;
#(
  parameter int MAX_SEGS      = 16,
  parameter int INIT_LEN      = 2,
  parameter int SAMPLE_FRAMES = 4,
  parameter int SKIP_SEGS     = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_active,
  input  logic       i_frame_tick,
  input  logic [9:0] i_head_x,
  input  logic [9:0] i_head_y,
  input  logic       i_food_ate,
  input  logic [9:0] i_pixel_x,
  input  logic [9:0] i_pixel_y,
  input  logic       i_video_on,
  output logic [3:0] o_vga_r,
  output logic [3:0] o_vga_g,
  output logic [3:0] o_vga_b,
  output logic [4:0] o_length,
  output logic       o_self_hit,
  output logic       o_scan_busy
);

  localparam int PW = $clog2(MAX_SEGS);
  localparam int CW = (SAMPLE_FRAMES > 1) ? $clog2(SAMPLE_FRAMES) : 1;
  localparam int LW = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  pos_t          head_in;
  pos_t          buf_q [MAX_SEGS];
  pos_t          buf_d [MAX_SEGS];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          food_q;
  logic          food_d;
  logic [11:0]   rgb_q;
  logic [11:0]   rgb_d;

  state_t        state_q;
  logic [LW-1:0] k_q;
  pos_t          head_q;
  logic          hit_q;
  logic          busy_q;

  logic          grow;
  logic          start;
  logic [MAX_SEGS-1:0] seg_on;
  logic          draw;
  logic [PW-1:0] scan_idx;
  pos_t          scan_seg;
  logic          scan_hit;

  assign head_in = {i_head_x, i_head_y};
  assign grow    = i_food_ate & ~food_q & i_active;
  assign start   = i_frame_tick & i_active;

  // Entry g holds logical segment k = wr_ptr-1-g
  for (genvar g = 0; g < MAX_SEGS; g++) begin : g_seg
    logic [PW-1:0] k;
    logic          in_box;

    assign k = wr_ptr_q - PW'(g) - PW'(1);

    box_overlap #(
      .AW(1),
      .AH(1),
      .BW(SEG_SIZE),
      .BH(SEG_SIZE)
    ) u_pix (
      .i_ax (i_pixel_x),
      .i_ay (i_pixel_y),
      .i_bx (buf_q[g].x),
      .i_by (buf_q[g].y),
      .o_hit(in_box)
    );

    assign seg_on[g] = in_box & (LW'(k) < len_q);
  end

  assign draw = |seg_on;

  assign scan_idx = wr_ptr_q - k_q[PW-1:0] - PW'(1);
  assign scan_seg = buf_q[scan_idx];

  box_overlap #(
    .AW(HEAD_W),
    .AH(HEAD_H),
    .BW(SEG_SIZE),
    .BH(SEG_SIZE)
  ) u_scan (
    .i_ax (head_q.x),
    .i_ay (head_q.y),
    .i_bx (scan_seg.x),
    .i_by (scan_seg.y),
    .o_hit(scan_hit)
  );

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    food_d   = i_food_ate;
    rgb_d    = (draw && i_video_on) ? BODY_COLOR : 12'h000;
    if (i_clear) begin
      for (int i = 0; i < MAX_SEGS; i++) begin
        buf_d[i] = head_in;
      end
      len_d = LW'(INIT_LEN);
      cnt_d = '0;
    end else begin
      if (start) begin
        if (cnt_q == CW'(SAMPLE_FRAMES - 1)) begin
          buf_d[wr_ptr_q] = head_in;
          wr_ptr_d        = wr_ptr_q + PW'(1);
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (grow && len_q < LW'(MAX_SEGS)) begin
        len_d = len_q + LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_SEGS; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      len_q    <= LW'(INIT_LEN);
      cnt_q    <= '0;
      food_q   <= 1'b0;
      rgb_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      food_q   <= food_d;
      rgb_q    <= rgb_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      head_q  <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (i_clear) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            head_q <= head_in;
            k_q    <= LW'(SKIP_SEGS);
            busy_q <= 1'b1;
            // Too short to reach past the skipped neck segments
            if (len_q <= LW'(SKIP_SEGS)) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (k_q < len_q && scan_hit) begin
            hit_q <= 1'b1;
          end
          if (k_q == LW'(MAX_SEGS - 1) ||
              k_q + LW'(1) >= len_q) begin
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q + LW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_vga_r     = rgb_q[11:8];
  assign o_vga_g     = rgb_q[7:4];
  assign o_vga_b     = rgb_q[3:0];
  assign o_length    = len_q;
  assign o_self_hit  = hit_q;
  assign o_scan_busy = busy_q;

endmodule

// File: tb/tb_snake_body_trail.sv
// Directed bench for snake_body_trail: sampling, growth,
// wrap-around, collision scan, clear and async reset.
module tb_snake_body_trail;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       active = 1'b0;
  logic       tick = 1'b0;
  logic       food = 1'b0;
  logic       von = 1'b0;
  logic [9:0] hx = '0;
  logic [9:0] hy = '0;
  logic [9:0] px = '0;
  logic [9:0] py = '0;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic [4:0] len;
  logic       hit;
  logic       busy;

  int vec = 0;
  int errs = 0;

  snake_body_trail dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .i_active    (active),
    .i_frame_tick(tick),
    .i_head_x    (hx),
    .i_head_y    (hy),
    .i_food_ate  (food),
    .i_pixel_x   (px),
    .i_pixel_y   (py),
    .i_video_on  (von),
    .o_vga_r     (r),
    .o_vga_g     (g),
    .o_vga_b     (b),
    .o_length    (len),
    .o_self_hit  (hit),
    .o_scan_busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic frame;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
  endtask

  task automatic grow;
    food = 1'b1;
    step();
    food = 1'b0;
    step();
  endtask

  task automatic look(input logic [9:0] x, input logic [9:0] y);
    px = x;
    py = y;
    step();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic setup_six(input int tk);
    for (int j = 0; j < 6; j++) begin
      if (j == 5 - tk) begin
        hx = 10'd300;
        hy = 10'd300;
      end else begin
        hx = 10'(400 + 100 * j);
        hy = 10'd100;
      end
      repeat (4) frame();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    active = 1'b1;
    von = 1'b1;
    px = 10'd5;
    py = 10'd5;
    step();
    step();
    vec++;
    if ({r, g, b} !== 12'h000) begin
      errs++;
      $display("FAIL rst_rgb got %h want 000", {r, g, b});
    end
    vec++;
    if (len !== 5'd2) begin
      errs++;
      $display("FAIL rst_len got %0d want 2", len);
    end
    vec++;
    if (hit !== 1'b0) begin
      errs++;
      $display("FAIL rst_hit got %b want 0", hit);
    end
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    rst = 1'b0;
    step();
    look(10'd5, 10'd5);
    vec++;
    if ({r, g, b} !== 12'h0A2) begin
      errs++;
      $display("FAIL rst_origin_seg got %h want 0a2", {r, g, b});
    end
  endtask

  task automatic test_sample;
    hx = 10'd100;
    hy = 10'd200;
    tick = 1'b1;
    step();
    tick = 1'b0;
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL short_scan_busy got %b want 1", busy);
    end
    step();
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL short_scan_idle got %b want 0", busy);
    end
    step();
    repeat (3) frame();
    look(10'd105, 10'd205);
    vec++;
    if ({r, g, b} !== 12'h0A2) begin
      errs++;
      $display("FAIL sample_draw got %h want 0a2", {r, g, b});
    end
    look(10'd116, 10'd205);
    vec++;
    if ({r, g, b} !== 12'h000) begin
      errs++;
      $display("FAIL sample_edge got %h want 000", {r, g, b});
    end
    von = 1'b0;
    look(10'd105, 10'd205);
    vec++;
    if ({r, g, b} !== 12'h000) begin
      errs++;
      $display("FAIL video_off got %h want 000", {r, g, b});
    end
    von = 1'b1;
    vec++;
    if (len !== 5'd2) begin
      errs++;
      $display("FAIL sample_len got %0d want 2", len);
    end
  endtask

  task automatic test_growth;
    repeat (2) begin
      food = 1'b1;
      repeat (3) step();
      food = 1'b0;
      step();
    end
    vec++;
    if (len !== 5'd4) begin
      errs++;
      $display("FAIL grow_two got %0d want 4", len);
    end
    food = 1'b1;
    repeat (20) step();
    food = 1'b0;
    step();
    vec++;
    if (len !== 5'd5) begin
      errs++;
      $display("FAIL grow_hold got %0d want 5", len);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    repeat (20) grow();
    vec++;
    if (len !== 5'd16) begin
      errs++;
      $display("FAIL saturate got %0d want 16", len);
    end
  endtask

  task automatic test_wrap;
    for (int j = 0; j < 17; j++) begin
      hx = 10'(30 * j);
      hy = 10'd400;
      repeat (4) frame();
    end
    look(10'd5, 10'd405);
    vec++;
    if ({r, g, b} !== 12'h000) begin
      errs++;
      $display("FAIL wrap_oldest got %h want 000", {r, g, b});
    end
    look(10'd35, 10'd405);
    vec++;
    if ({r, g, b} !== 12'h0A2) begin
      errs++;
      $display("FAIL wrap_tail got %h want 0a2", {r, g, b});
    end
    look(10'd485, 10'd405);
    vec++;
    if ({r, g, b} !== 12'h0A2) begin
      errs++;
      $display("FAIL wrap_newest got %h want 0a2", {r, g, b});
    end
  endtask

  task automatic test_skip;
    do_reset();
    repeat (4) grow();
    setup_six(1);
    hx = 10'd290;
    hy = 10'd290;
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (10) step();
    vec++;
    if (hit !== 1'b0) begin
      errs++;
      $display("FAIL skip_neck got %b want 0", hit);
    end
  endtask

  task automatic test_self_hit;
    int n;
    do_reset();
    repeat (4) grow();
    setup_six(4);
    vec++;
    if (hit !== 1'b0) begin
      errs++;
      $display("FAIL pre_hit got %b want 0", hit);
    end
    hx = 10'd290;
    hy = 10'd290;
    tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      step();
    end
    vec++;
    if (n !== 4) begin
      errs++;
      $display("FAIL busy_cycles got %0d want 4", n);
    end
    vec++;
    if (hit !== 1'b1) begin
      errs++;
      $display("FAIL self_hit got %b want 1", hit);
    end
    hx = 10'd10;
    hy = 10'd500;
    frame();
    repeat (8) step();
    vec++;
    if (hit !== 1'b1) begin
      errs++;
      $display("FAIL hit_sticky got %b want 1", hit);
    end
  endtask

  task automatic test_clear;
    hx = 10'd290;
    hy = 10'd290;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_scan got %b want 1", busy);
    end
    clear = 1'b1;
    hx = 10'd50;
    hy = 10'd60;
    step();
    clear = 1'b0;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL clr_busy got %b want 0", busy);
    end
    vec++;
    if (hit !== 1'b0) begin
      errs++;
      $display("FAIL clr_hit got %b want 0", hit);
    end
    vec++;
    if (len !== 5'd2) begin
      errs++;
      $display("FAIL clr_len got %0d want 2", len);
    end
    look(10'd55, 10'd65);
    vec++;
    if ({r, g, b} !== 12'h0A2) begin
      errs++;
      $display("FAIL clr_draw got %h want 0a2", {r, g, b});
    end
    look(10'd305, 10'd305);
    vec++;
    if ({r, g, b} !== 12'h000) begin
      errs++;
      $display("FAIL clr_old got %h want 000", {r, g, b});
    end
  endtask

  task automatic test_async_reset;
    repeat (3) grow();
    px = 10'd55;
    py = 10'd65;
    tick = 1'b1;
    step();
    tick = 1'b0;
    vec++;
    if ({r, g, b} !== 12'h0A2 || busy !== 1'b1) begin
      errs++;
      $display("FAIL pre_async got %h/%b want 0a2/1",
               {r, g, b}, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if ({r, g, b} !== 12'h000) begin
      errs++;
      $display("FAIL async_rgb got %h want 000", {r, g, b});
    end
    vec++;
    if (len !== 5'd2 || busy !== 1'b0 || hit !== 1'b0) begin
      errs++;
      $display("FAIL async_state got %0d/%b/%b want 2/0/0",
               len, busy, hit);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_sample();
    test_growth();
    test_saturate();
    test_wrap();
    test_skip();
    test_self_hit();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
